// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_pkg                                                |
// | Description : Shared widths, types and constants for the 16-bit core |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_ID_W = 4;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [DATA_W-1:0]   word_t;

    localparam reg_id_t REG_ZERO = 4'd0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/decoder_4_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decoder_4_16                                           |
// | Description : 4-to-16 one-hot decoder for register write select      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module decoder_4_16 (
    input  logic [3:0]  sel,
    output logic [15:0] line
);

    assign line = 16'd1 << sel;

endmodule : decoder_4_16
`default_nettype wire

// File: rtl/reg_word_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : reg_word_16                                            |
// | Description : 16-bit register with load enable and sync active-low   |
// |               clear                                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module reg_word_16
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    word_t data_d;
    word_t data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : reg_word_16
`default_nettype wire

// File: rtl/register_file_16x16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : register_file_16x16                                    |
// | Description : 16x16 register file, 2 async reads, 1 sync write,      |
// |               R0 hardwired to zero, write-before-read bypass         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module register_file_16x16 #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int REG_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_ID_W-1:0] src_reg1,
    input  logic [REG_ID_W-1:0] src_reg2,
    input  logic [REG_ID_W-1:0] dst_reg,
    input  logic                write_reg,
    input  logic [DATA_W-1:0]   dst_data,
    output logic [DATA_W-1:0]   src_data1,
    output logic [DATA_W-1:0]   src_data2
);

    import cpu_pkg::*;

    logic [NUM_REGS-1:0] line_w;
    logic [NUM_REGS-1:0] wen_w;
    logic [DATA_W-1:0]   regs_w [NUM_REGS];
    logic                bypass1_w;
    logic                bypass2_w;

    decoder_4_16 u_dec (
        .sel  (dst_reg),
        .line (line_w)
    );

    assign wen_w     = line_w & {NUM_REGS{write_reg & rst_n}};
    assign regs_w[0] = '0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
            reg_word_16 u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (wen_w[i]),
                .d     (dst_data),
                .q     (regs_w[i])
            );
        end
    endgenerate

    // wen_w already folds in write_reg, rst_n and the dst_reg match, so
    // indexing it by the source id is exactly the bypass condition.
    assign bypass1_w = wen_w[src_reg1] & (src_reg1 != REG_ZERO);
    assign bypass2_w = wen_w[src_reg2] & (src_reg2 != REG_ZERO);

    always_comb begin
        src_data1 = '0;
        src_data2 = '0;
        if (rst_n) begin
            src_data1 = bypass1_w ? dst_data : regs_w[src_reg1];
            src_data2 = bypass2_w ? dst_data : regs_w[src_reg2];
        end
    end

endmodule : register_file_16x16
`default_nettype wire

// File: tb/tb_register_file_16x16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_register_file_16x16                                 |
// | Description : Self-checking bench: directed vector table, random     |
// |               traffic against a reference array model                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_register_file_16x16;

    logic        clk;
    logic        rst_n;
    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic [3:0]  dst_reg;
    logic        write_reg;
    logic [15:0] dst_data;
    logic [15:0] src_data1;
    logic [15:0] src_data2;

    int n_checks;
    int n_fail;

    logic [15:0] model [16];

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [3:0]  dst;
        logic [15:0] data;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs[$];

    register_file_16x16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_reg1  (src_reg1),
        .src_reg2  (src_reg2),
        .dst_reg   (dst_reg),
        .write_reg (write_reg),
        .dst_data  (dst_data),
        .src_data1 (src_data1),
        .src_data2 (src_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic w, input logic [3:0] d,
                                input logic [15:0] dd, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [15:0] e1,
                                input logic [15:0] e2);
        vec_t v;
        v.rst_n = r; v.wr = w; v.dst = d; v.data = dd;
        v.s1 = s1; v.s2 = s2; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    // Architectural read as seen by decode in the current cycle.
    function automatic logic [15:0] ref_read(input logic [3:0] src);
        if (!rst_n)                                return 16'h0000;
        if (src == 4'd0)                           return 16'h0000;
        if (write_reg && dst_reg == src)           return dst_data;
        return model[src];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] d,
                         input logic [15:0] dd, input logic [3:0] s1, input logic [3:0] s2);
        rst_n = r; write_reg = w; dst_reg = d; dst_data = dd;
        src_reg1 = s1; src_reg2 = s2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) model[k] = 16'h0000;
        end else if (write_reg && dst_reg != 4'd0) begin
            model[dst_reg] = dst_data;
        end
        #1;
    endtask

    task automatic model_cycle(input string tag);
        @(negedge clk);
        check({tag, "_p1"}, src_data1, ref_read(src_reg1));
        check({tag, "_p2"}, src_data2, ref_read(src_reg2));
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 16; k++) model[k] = 16'h0000;

        // Reset state, reset beating a write
        vecs.push_back(mk(0, 1, 4'd4, 16'hFFFF, 4'd4, 4'd0, 16'h0000, 16'h0000));
        // Fill R1..R15 with FFFF: port 1 bypasses, port 2 sees the previous write
        for (int i = 1; i < 16; i++)
            vecs.push_back(mk(1, 1, 4'(i), 16'hFFFF, 4'(i), 4'(i - 1),
                              16'hFFFF, (i == 1) ? 16'h0000 : 16'hFFFF));
        vecs.push_back(mk(0, 1, 4'd9, 16'h5555, 4'd9, 4'd1, 16'h0000, 16'h0000));
        for (int i = 1; i < 16; i++)
            vecs.push_back(mk(1, 0, 4'd0, 16'h0000, 4'(i), 4'(16 - i), 16'h0000, 16'h0000));
        // Basic write/read
        vecs.push_back(mk(1, 1, 4'd5,  16'hA5A5, 4'd5, 4'd12, 16'hA5A5, 16'h0000));
        vecs.push_back(mk(1, 1, 4'd12, 16'h1234, 4'd5, 4'd12, 16'hA5A5, 16'h1234));
        vecs.push_back(mk(1, 0, 4'd0,  16'h0000, 4'd5, 4'd12, 16'hA5A5, 16'h1234));
        vecs.push_back(mk(1, 0, 4'd0,  16'h0000, 4'd1, 4'd13, 16'h0000, 16'h0000));
        // Dual-port bypass on R3
        vecs.push_back(mk(1, 1, 4'd3, 16'h0001, 4'd3, 4'd0, 16'h0001, 16'h0000));
        vecs.push_back(mk(1, 1, 4'd3, 16'hBEEF, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF));
        vecs.push_back(mk(1, 0, 4'd3, 16'h0000, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF));
        // R0 immutability
        vecs.push_back(mk(1, 1, 4'd0, 16'h7777, 4'd0, 4'd0, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 4'd0, 16'h0000, 4'd0, 4'd5, 16'h0000, 16'hA5A5));
        // Write disabled
        vecs.push_back(mk(1, 1, 4'd7, 16'h0042, 4'd7, 4'd7, 16'h0042, 16'h0042));
        vecs.push_back(mk(1, 0, 4'd7, 16'hDEAD, 4'd7, 4'd7, 16'h0042, 16'h0042));
        vecs.push_back(mk(1, 0, 4'd0, 16'h0000, 4'd7, 4'd0, 16'h0042, 16'h0000));
        // Reset beats write, then next write proceeds
        vecs.push_back(mk(0, 1, 4'd9, 16'h5555, 4'd9, 4'd7, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 4'd0, 16'h0000, 4'd9, 4'd7, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 4'd9, 16'h1111, 4'd9, 4'd0, 16'h1111, 16'h0000));
        vecs.push_back(mk(1, 0, 4'd0, 16'h0000, 4'd9, 4'd9, 16'h1111, 16'h1111));
        // Reset landing in the middle of back-to-back writes
        vecs.push_back(mk(1, 1, 4'd2, 16'hAAAA, 4'd2, 4'd0, 16'hAAAA, 16'h0000));
        vecs.push_back(mk(0, 1, 4'd4, 16'hBBBB, 4'd4, 4'd2, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 4'd6, 16'hCCCC, 4'd2, 4'd4, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 0, 4'd0, 16'h0000, 4'd6, 4'd4, 16'hCCCC, 16'h0000));

        drive(0, 0, 4'd0, 16'h0000, 4'd0, 4'd0);
        tick();
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].wr, vecs[i].dst, vecs[i].data, vecs[i].s1, vecs[i].s2);
            @(negedge clk);
            check($sformatf("vec%0d_p1", i), src_data1, vecs[i].e1);
            check($sformatf("vec%0d_p2", i), src_data2, vecs[i].e2);
            tick();
        end

        // Random traffic against the array model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            model_cycle("rand");
        end

        // Hand sequence: reset, load distinct values, read back every id pair
        drive(0, 0, 4'd0, 16'h0000, 4'd0, 4'd0);
        model_cycle("seq_rst");
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 4'(i), 16'($urandom), 4'(i), 4'(15 - i));
            model_cycle("seq_wr");
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 4'(i), 16'($urandom), 4'(i), 4'(15 - i));
            model_cycle("seq_rd");
        end
        drive(1, 1, 4'd11, 16'h3C3C, 4'd11, 4'd11);
        model_cycle("seq_triple");
        drive(1, 0, 4'd0, 16'h0000, 4'd11, 4'd0);
        model_cycle("seq_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file_16x16
`default_nettype wire
